// File: rtl/log_arb_pkg.sv
// Shared state encoding, framing characters and counter width for the log arbiter.
package log_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DRAIN,
        ST_SAMPLE
    } arb_state_t;

    localparam logic [7:0] SOM_CHAR = 8'h5E;  // '^'
    localparam logic [7:0] EOM_CHAR = 8'h23;  // '#'
    localparam int         CNT_W    = 8;

endpackage

// File: rtl/log_arb_sat_cnt.sv
// Statistics counter that sticks at its maximum value instead of wrapping.
module log_arb_sat_cnt
    import log_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/log_arbiter.sv
// Arbitrates two log-character sources onto one cpu_checker stream and
// collects the checker verdict plus error/abort statistics per message.
module log_arbiter
    import log_arb_pkg::*;
#(
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       src0_char,
    input  logic             src0_valid,
    output logic             src0_ready,
    input  logic [7:0]       src1_char,
    input  logic             src1_valid,
    output logic             src1_ready,
    output logic [7:0]       out_char,
    output logic             grant_busy,
    output logic             grant_id,
    input  logic [1:0]       chk_format,
    input  logic [3:0]       chk_error,
    output logic             res_valid,
    output logic             res_src,
    output logic [1:0]       res_format,
    output logic [3:0]       res_error,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    arb_state_t       state, state_next;
    logic [LEN_W-1:0] len, len_next, len_inc;
    logic [7:0]       out_next, fwd_char;
    logic             last_grant, last_next, grant_next;
    logic             som0, som1, take0, take1, fwd_valid;
    logic             rdy0, rdy1;
    logic             abort_inc, res_load, err0_inc, err1_inc;

    assign som0 = src0_valid && (src0_char == SOM_CHAR);
    assign som1 = src1_valid && (src1_char == SOM_CHAR);

    // On a '^' collision the source that was not granted last wins.
    assign take0 = som0 && (!som1 || last_grant);
    assign take1 = som1 && (!som0 || !last_grant);

    assign fwd_char  = grant_id ? src1_char : src0_char;
    assign fwd_valid = grant_id ? src1_valid : src0_valid;
    assign len_inc   = len + LEN_W'(1);

    always_comb begin
        state_next = state;
        len_next   = len;
        out_next   = IDLE_CHAR;
        grant_next = grant_id;
        last_next  = last_grant;
        rdy0       = 1'b0;
        rdy1       = 1'b0;
        abort_inc  = 1'b0;
        res_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy0 = src0_valid && !(som0 && take1);
                rdy1 = src1_valid && !(som1 && take0);
                if (take0 || take1) begin
                    state_next = ST_FWD;
                    out_next   = SOM_CHAR;
                    len_next   = LEN_W'(1);
                    grant_next = take1;
                    last_next  = take1;
                end
            end
            ST_FWD: begin
                rdy0 = !grant_id;
                rdy1 = grant_id;
                if (fwd_valid) begin
                    out_next = fwd_char;
                    if (fwd_char == EOM_CHAR) begin
                        state_next = ST_DRAIN;
                    end else if (fwd_char == SOM_CHAR) begin
                        len_next = LEN_W'(1);
                    end else begin
                        len_next = len_inc;
                        if (len_inc == LEN_W'(MAX_LEN)) begin
                            state_next = ST_DRAIN;
                            abort_inc  = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                state_next = ST_IDLE;
                res_load   = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign src0_ready = rdy0 && !reset;
    assign src1_ready = rdy1 && !reset;
    assign grant_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The checker verdict is captured during SAMPLE and presented one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_char   <= IDLE_CHAR;
            len        <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_src    <= 1'b0;
            res_format <= 2'b00;
            res_error  <= 4'b0000;
        end else begin
            out_char   <= out_next;
            len        <= len_next;
            grant_id   <= grant_next;
            last_grant <= last_next;
            res_valid  <= res_load;
            if (res_load) begin
                res_src    <= grant_id;
                res_format <= chk_format;
                res_error  <= chk_error;
            end
        end
    end

    assign err0_inc = res_load && (chk_error != 4'd0) && !grant_id;
    assign err1_inc = res_load && (chk_error != 4'd0) && grant_id;

    log_arb_sat_cnt u_err_cnt0 (
        .clk   (clk),
        .reset (reset),
        .inc   (err0_inc),
        .count (err_cnt0)
    );

    log_arb_sat_cnt u_err_cnt1 (
        .clk   (clk),
        .reset (reset),
        .inc   (err1_inc),
        .count (err_cnt1)
    );

    log_arb_sat_cnt u_abort_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (abort_inc),
        .count (abort_cnt)
    );

endmodule
